// File: rtl/digitos_pkg.sv
// Shared digit-handling constants and FSM encoding for the composition and
// decomposition/display blocks.
package digitos_pkg;

  localparam int DIGIT_W = 4;
  localparam int RADIX   = 10;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } estado_t;

  function automatic logic es_no_bcd(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/componer_desde_digitos_mul10_add.sv
// Combinational Horner step: resultado = acc*10 + digito, wrapped to OUT_W bits.
module mul10_add
  import digitos_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [OUT_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digito,
  output logic [OUT_W-1:0]   resultado
);

  // Bits above OUT_W are discarded anyway, so the shift-add is carried out
  // at OUT_W width; the low OUT_W bits match the wide sum exactly.
  logic [OUT_W-1:0] por8;
  logic [OUT_W-1:0] por2;

  assign por8      = acc << 3;
  assign por2      = acc << 1;
  assign resultado = por8 + por2 + OUT_W'(digito);

endmodule

// File: rtl/componer_desde_digitos.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Optional non-BCD digit detection when BCD_CHECK_EN is defined.
//
// state   | meaning
// IDLE    | in_ready high, waiting for a digit word
// CONV    | folding latched digits into acc, idx counts down to 0
// DONE    | result presented, waiting for out_ready
module componer_desde_digitos
  import digitos_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int OUT_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIGIT_W*N_DIGITS-1:0] digitos,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            numero,
  output logic                        error
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  estado_t                      estado;
  estado_t                      estado_sig;
  logic [DIGIT_W*N_DIGITS-1:0]  digitos_q;
  logic [OUT_W-1:0]             acc;
  logic [OUT_W-1:0]             acc_sig;
  logic [OUT_W-1:0]             numero_q;
  logic [IDX_W-1:0]             idx;
  logic [DIGIT_W-1:0]           digito_act;
  logic                         aceptar;
  logic                         ultimo;
  logic                         retirar;

  assign in_ready  = (estado == ST_IDLE);
  assign out_valid = (estado == ST_DONE);
  assign aceptar   = in_ready && in_valid;
  assign ultimo    = (estado == ST_CONV) && (idx == '0);
  assign retirar   = out_valid && out_ready;
  assign numero    = numero_q;

  assign digito_act = digitos_q[DIGIT_W*int'(idx) +: DIGIT_W];

  mul10_add #(
    .OUT_W (OUT_W)
  ) u_mul10_add (
    .acc       (acc),
    .digito    (digito_act),
    .resultado (acc_sig)
  );

`ifdef BCD_CHECK_EN
  logic bcd_mal;
  logic error_q;

  always_comb begin
    bcd_mal = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (es_no_bcd(digitos_q[DIGIT_W*i +: DIGIT_W])) begin
        bcd_mal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else if (ultimo) begin
      error_q <= bcd_mal;
    end else if (retirar) begin
      error_q <= 1'b0;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado <= ST_IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      ST_IDLE: if (in_valid) estado_sig = ST_CONV;
      ST_CONV: if (idx == '0) estado_sig = ST_DONE;
      ST_DONE: if (out_ready) estado_sig = ST_IDLE;
      default: estado_sig = ST_IDLE;
    endcase
  end

  // Datapath: digits are captured only on acceptance, so later changes on
  // the input bus cannot disturb a conversion in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digitos_q <= '0;
      acc       <= '0;
      idx       <= '0;
      numero_q  <= '0;
    end else if (aceptar) begin
      digitos_q <= digitos;
      acc       <= '0;
      idx       <= IDX_W'(N_DIGITS - 1);
    end else if (estado == ST_CONV) begin
      acc <= acc_sig;
      idx <= idx - 1'b1;
      if (ultimo) begin
`ifdef BCD_CHECK_EN
        numero_q <= bcd_mal ? '0 : acc_sig;
`else
        numero_q <= acc_sig;
`endif
      end
    end
  end

endmodule
